// File: rtl/cpu_lockstep_cmp.sv
// Lockstep bus comparator: buffers the DUV and reference 6502 bus streams in
// per-side FIFOs and compares them pair by pair in arrival order.
module cpu_lockstep_cmp #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   duv_valid,
  input  logic [15:0]            duv_addr,
  input  logic [7:0]             duv_data,
  input  logic                   duv_rw,
  input  logic                   ref_valid,
  input  logic [15:0]            ref_addr,
  input  logic [7:0]             ref_data,
  input  logic                   ref_rw,
  output logic                   cmp_valid,
  output logic                   cmp_match,
  output logic                   mismatch,
  output logic                   overflow,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic [15:0]            first_duv_addr,
  output logic [7:0]             first_duv_data,
  output logic                   first_duv_rw,
  output logic [15:0]            first_ref_addr,
  output logic [7:0]             first_ref_data,
  output logic                   first_ref_rw,
  output logic [$clog2(DEPTH):0] duv_level,
  output logic [$clog2(DEPTH):0] ref_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 25;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // Side 0 is the DUV stream, side 1 the reference stream.
  logic             side_valid    [2];
  logic [ENT_W-1:0] side_entry    [2];
  logic [ENT_W-1:0] side_head     [2];
  logic [LVL_W-1:0] side_level    [2];
  logic             side_full     [2];
  logic             side_nonempty [2];
  logic             side_push     [2];
  logic             pop;

  assign side_valid[0] = duv_valid;
  assign side_valid[1] = ref_valid;
  assign side_entry[0] = {duv_addr, duv_data, duv_rw};
  assign side_entry[1] = {ref_addr, ref_data, ref_rw};
  assign pop = side_nonempty[0] & side_nonempty[1] & ~clr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_side
      logic [ENT_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      logic [LVL_W-1:0] level_q, level_d;

      // Fullness uses the pre-edge level, so a same-edge pop cannot make room.
      assign side_full[gi]     = (level_q == FULL_LVL);
      assign side_nonempty[gi] = (level_q != '0);
      assign side_push[gi]     = side_valid[gi] & ~side_full[gi] & ~clr;
      assign side_head[gi]     = mem[rd_ptr_q];
      assign side_level[gi]    = level_q;

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          level_d  = '0;
        end else begin
          if (side_push[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop)           rd_ptr_d = rd_ptr_q + 1'b1;
          case ({side_push[gi], pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          level_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          level_q  <= level_d;
        end
      end

      always_ff @(posedge clk) begin
        if (side_push[gi]) mem[wr_ptr_q] <= side_entry[gi];
      end
    end
  endgenerate

  logic             pair_match;
  logic             cmp_valid_q, cmp_valid_d;
  logic             cmp_match_q, cmp_match_d;
  logic             mismatch_q, mismatch_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [ENT_W-1:0] first_duv_q, first_duv_d;
  logic [ENT_W-1:0] first_ref_q, first_ref_d;

  assign pair_match = (side_head[0] == side_head[1]);

  always_comb begin
    cmp_valid_d    = pop;
    cmp_match_d    = pop & pair_match;
    mismatch_d     = mismatch_q;
    overflow_d     = overflow_q;
    match_cnt_d    = match_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    first_duv_d    = first_duv_q;
    first_ref_d    = first_ref_q;
    if (clr) begin
      mismatch_d     = 1'b0;
      overflow_d     = 1'b0;
      match_cnt_d    = '0;
      mismatch_cnt_d = '0;
      first_duv_d    = '0;
      first_ref_d    = '0;
    end else begin
      if (pop && pair_match && (match_cnt_q != '1)) match_cnt_d = match_cnt_q + 1'b1;
      if (pop && !pair_match) begin
        if (mismatch_cnt_q != '1) mismatch_cnt_d = mismatch_cnt_q + 1'b1;
        mismatch_d = 1'b1;
        // Only the first divergence is captured; later ones leave it intact.
        if (!mismatch_q) begin
          first_duv_d = side_head[0];
          first_ref_d = side_head[1];
        end
      end
      if ((side_valid[0] && side_full[0]) || (side_valid[1] && side_full[1])) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_valid_q    <= 1'b0;
      cmp_match_q    <= 1'b0;
      mismatch_q     <= 1'b0;
      overflow_q     <= 1'b0;
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      first_duv_q    <= '0;
      first_ref_q    <= '0;
    end else begin
      cmp_valid_q    <= cmp_valid_d;
      cmp_match_q    <= cmp_match_d;
      mismatch_q     <= mismatch_d;
      overflow_q     <= overflow_d;
      match_cnt_q    <= match_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      first_duv_q    <= first_duv_d;
      first_ref_q    <= first_ref_d;
    end
  end

  assign cmp_valid    = cmp_valid_q;
  assign cmp_match    = cmp_match_q;
  assign mismatch     = mismatch_q;
  assign overflow     = overflow_q;
  assign match_cnt    = match_cnt_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign {first_duv_addr, first_duv_data, first_duv_rw} = first_duv_q;
  assign {first_ref_addr, first_ref_data, first_ref_rw} = first_ref_q;
  assign duv_level    = side_level[0];
  assign ref_level    = side_level[1];
endmodule

// File: tb/tb_cpu_lockstep_cmp.sv
// Bench for cpu_lockstep_cmp: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based model of the two streams.
module tb_cpu_lockstep_cmp;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic duv_valid = 1'b0, ref_valid = 1'b0;
  logic [15:0] duv_addr = '0, ref_addr = '0;
  logic [7:0]  duv_data = '0, ref_data = '0;
  logic        duv_rw = 1'b0, ref_rw = 1'b0;

  logic        cmp_valid, cmp_match, mismatch, overflow;
  logic [15:0] match_cnt, mismatch_cnt;
  logic [15:0] first_duv_addr, first_ref_addr;
  logic [7:0]  first_duv_data, first_ref_data;
  logic        first_duv_rw, first_ref_rw;
  logic [3:0]  duv_level, ref_level;

  logic        s_cmp_valid, s_cmp_match, s_mismatch, s_overflow;
  logic [3:0]  s_match_cnt, s_mismatch_cnt;
  logic [15:0] s_first_duv_addr, s_first_ref_addr;
  logic [7:0]  s_first_duv_data, s_first_ref_data;
  logic        s_first_duv_rw, s_first_ref_rw;
  logic [3:0]  s_duv_level, s_ref_level;

  always #5 clk = ~clk;

  cpu_lockstep_cmp #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .duv_valid(duv_valid), .duv_addr(duv_addr), .duv_data(duv_data), .duv_rw(duv_rw),
    .ref_valid(ref_valid), .ref_addr(ref_addr), .ref_data(ref_data), .ref_rw(ref_rw),
    .cmp_valid(cmp_valid), .cmp_match(cmp_match), .mismatch(mismatch), .overflow(overflow),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
    .first_duv_addr(first_duv_addr), .first_duv_data(first_duv_data), .first_duv_rw(first_duv_rw),
    .first_ref_addr(first_ref_addr), .first_ref_data(first_ref_data), .first_ref_rw(first_ref_rw),
    .duv_level(duv_level), .ref_level(ref_level)
  );

  cpu_lockstep_cmp #(.DEPTH(DEPTH), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .duv_valid(duv_valid), .duv_addr(duv_addr), .duv_data(duv_data), .duv_rw(duv_rw),
    .ref_valid(ref_valid), .ref_addr(ref_addr), .ref_data(ref_data), .ref_rw(ref_rw),
    .cmp_valid(s_cmp_valid), .cmp_match(s_cmp_match), .mismatch(s_mismatch), .overflow(s_overflow),
    .match_cnt(s_match_cnt), .mismatch_cnt(s_mismatch_cnt),
    .first_duv_addr(s_first_duv_addr), .first_duv_data(s_first_duv_data), .first_duv_rw(s_first_duv_rw),
    .first_ref_addr(s_first_ref_addr), .first_ref_data(s_first_ref_data), .first_ref_rw(s_first_ref_rw),
    .duv_level(s_duv_level), .ref_level(s_ref_level)
  );

  // Reference model: two in-order queues and plain counters.
  logic [24:0] mq_duv[$];
  logic [24:0] mq_ref[$];
  int          m_match = 0, m_mis = 0;
  bit          m_mismatch = 0, m_ovf = 0, m_cv = 0, m_cm = 0;
  logic [24:0] m_fd = '0, m_fr = '0;

  int n_vec = 0;
  int n_err = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    mq_duv.delete();
    mq_ref.delete();
    m_match = 0; m_mis = 0;
    m_mismatch = 0; m_ovf = 0; m_cv = 0; m_cm = 0;
    m_fd = '0; m_fr = '0;
  endtask

  task automatic model_edge();
    int nd, nr;
    logic [24:0] a, b;
    nd = mq_duv.size();
    nr = mq_ref.size();
    m_cv = 0;
    m_cm = 0;
    if (clr) begin
      model_reset();
    end else begin
      if (nd > 0 && nr > 0) begin
        a = mq_duv.pop_front();
        b = mq_ref.pop_front();
        m_cv = 1;
        m_cm = (a == b);
        if (a == b) m_match++;
        else begin
          if (!m_mismatch) begin m_fd = a; m_fr = b; end
          m_mismatch = 1;
          m_mis++;
        end
      end
      if (duv_valid) begin
        if (nd == DEPTH) m_ovf = 1;
        else mq_duv.push_back({duv_addr, duv_data, duv_rw});
      end
      if (ref_valid) begin
        if (nr == DEPTH) m_ovf = 1;
        else mq_ref.push_back({ref_addr, ref_data, ref_rw});
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    check("cmp_valid", 32'(cmp_valid), 32'(m_cv));
    check("cmp_match", 32'(cmp_match), 32'(m_cm));
    check("mismatch", 32'(mismatch), 32'(m_mismatch));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("match_cnt", 32'(match_cnt), 32'(sat(m_match, 65535)));
    check("mismatch_cnt", 32'(mismatch_cnt), 32'(sat(m_mis, 65535)));
    check("duv_level", 32'(duv_level), 32'(mq_duv.size()));
    check("ref_level", 32'(ref_level), 32'(mq_ref.size()));
    check("first_duv", 32'({first_duv_addr, first_duv_data, first_duv_rw}), 32'(m_fd));
    check("first_ref", 32'({first_ref_addr, first_ref_data, first_ref_rw}), 32'(m_fr));
    check("sat_match_cnt", 32'(s_match_cnt), 32'(sat(m_match, 15)));
    check("sat_mismatch_cnt", 32'(s_mismatch_cnt), 32'(sat(m_mis, 15)));
  endtask

  task automatic drive(input bit dv, input logic [24:0] de, input bit rv, input logic [24:0] re);
    duv_valid = dv;
    {duv_addr, duv_data, duv_rw} = de;
    ref_valid = rv;
    {ref_addr, ref_data, ref_rw} = re;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    drive(0, '0, 0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clr();
    drive(0, '0, 0, '0);
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  function automatic logic [24:0] ent(input int i);
    logic [15:0] a;
    logic [7:0]  d;
    a = 16'(16'h1000 + i);
    d = 8'(i * 3);
    return {a, d, 1'(i % 2)};
  endfunction

  logic [24:0] stream [4096];

  initial begin
    int di, ri, dprob, rprob;
    logic [24:0] re;

    // Reset state while rst_n is held low.
    #2;
    check_all();
    check("rst_cmp_valid", 32'(cmp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lockstep match: two identical pairs on consecutive cycles.
    drive(1, {16'hFFFC, 8'h00, 1'b1}, 1, {16'hFFFC, 8'h00, 1'b1});
    step();
    drive(1, {16'hFFFD, 8'h80, 1'b1}, 1, {16'hFFFD, 8'h80, 1'b1});
    step();
    idle(1);
    check("lockstep_pulse2", 32'(cmp_valid), 32'd1);
    idle(1);
    check("lockstep_match_cnt", 32'(match_cnt), 32'd2);
    check("lockstep_mismatch", 32'(mismatch), 32'd0);

    // Data mismatch and first_* capture that later mismatches leave alone.
    do_clr();
    drive(1, {16'h0200, 8'h12, 1'b0}, 1, {16'h0200, 8'h13, 1'b0});
    step();
    idle(1);
    check("mis_cmp_match", 32'(cmp_match), 32'd0);
    check("mis_first_duv_data", 32'(first_duv_data), 32'h12);
    check("mis_first_ref_data", 32'(first_ref_data), 32'h13);
    check("mis_cnt", 32'(mismatch_cnt), 32'd1);
    drive(1, {16'h0300, 8'h55, 1'b1}, 1, {16'h0300, 8'h56, 1'b1});
    step();
    idle(2);
    check("mis_first_hold", 32'(first_duv_data), 32'h12);
    check("mis_cnt2", 32'(mismatch_cnt), 32'd2);

    // Skew and overflow: 9 DUV pushes with REF idle, then 8 matching REF.
    do_clr();
    for (int i = 0; i < 9; i++) begin drive(1, ent(i), 0, '0); step(); end
    check("skew_duv_level", 32'(duv_level), 32'd8);
    check("skew_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin drive(0, '0, 1, ent(i)); step(); end
    idle(2);
    check("skew_match_cnt", 32'(match_cnt), 32'd8);
    check("skew_duv_drained", 32'(duv_level), 32'd0);

    // Full DUV FIFO with a pop on the same edge as a DUV push.
    do_clr();
    for (int i = 0; i < 8; i++) begin drive(1, ent(i), 0, '0); step(); end
    drive(0, '0, 1, ent(0));
    step();
    drive(1, ent(50), 0, '0);
    step();
    check("fullpop_duv_level", 32'(duv_level), 32'd7);
    check("fullpop_overflow", 32'(overflow), 32'd1);
    idle(1);

    // Saturation: 20 matching pairs.
    do_clr();
    for (int i = 0; i < 20; i++) begin drive(1, ent(i), 1, ent(i)); step(); end
    idle(2);
    check("sat_15", 32'(s_match_cnt), 32'd15);
    check("sat_wide_20", 32'(match_cnt), 32'd20);

    // clr with 3 DUV entries queued, a REF head waiting, and duv_valid=1.
    do_clr();
    drive(1, ent(0), 0, '0); step();
    drive(1, ent(1), 0, '0); step();
    drive(1, ent(2), 1, ent(0)); step();
    drive(1, ent(3), 0, '0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_duv_level", 32'(duv_level), 32'd0);
    check("clr_ref_level", 32'(ref_level), 32'd0);
    check("clr_no_cmp", 32'(cmp_valid), 32'd0);
    idle(2);

    // Randomized traffic with varying skew, occasional corruption and clr.
    for (int i = 0; i < 4096; i++) stream[i] = 25'($urandom);
    di = 0; ri = 0; dprob = 60; rprob = 60;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      if (cyc % 200 == 0) begin
        dprob = $urandom_range(20, 95);
        rprob = $urandom_range(20, 95);
      end
      duv_valid = ($urandom_range(0, 99) < dprob);
      ref_valid = ($urandom_range(0, 99) < rprob);
      {duv_addr, duv_data, duv_rw} = stream[di % 4096];
      re = stream[ri % 4096];
      if ($urandom_range(0, 29) == 0) re[8:1] = re[8:1] ^ 8'h01;
      {ref_addr, ref_data, ref_rw} = re;
      clr = ($urandom_range(0, 299) == 0);
      if (duv_valid) di++;
      if (ref_valid) ri++;
      if (clr) begin
        di = (di > ri) ? di : ri;
        ri = di;
      end
      step();
      clr = 1'b0;
    end
    idle(DEPTH + 2);

    // Asynchronous reset between edges while a compare pulse is showing.
    do_clr();
    drive(1, ent(1), 1, ent(1)); step();
    drive(1, ent(2), 1, ent(2)); step();
    drive(0, '0, 0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("async_cmp_valid", 32'(cmp_valid), 32'd0);
    check("async_duv_level", 32'(duv_level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    drive(0, '0, 1, ent(2)); step();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
